// File: rtl/timer_pkg.sv
// Shared constants for the microwave timer keypad path: key count, BCD width
// and the encoder's 3-bit state encoding.
package timer_pkg;

    localparam int BCD_W = 4;
    localparam int KEYS  = 10;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] DEBOUNCE = 3'd1;
    localparam logic [2:0] SETUP    = 3'd2;
    localparam logic [2:0] STROBE   = 3'd3;
    localparam logic [2:0] RELEASE  = 3'd4;

endpackage

// File: rtl/onehot10_to_bcd.sv
// Combinational key decoder: index of the single pressed key as BCD, plus a
// flag that is high only when exactly one key line is asserted.
module onehot10_to_bcd
    import timer_pkg::*;
(
    input  logic [KEYS-1:0]  keys_i,
    output logic [BCD_W-1:0] code_o,
    output logic             valid_o
);

    logic [3:0] ones;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned; otherwise synthesis would infer a latch.
        code_o = '0;
        ones   = '0;
        for (int i = 0; i < KEYS; i++) begin
            if (keys_i[i]) begin
                code_o = BCD_W'(i);
                ones   = ones + 4'd1;
            end
        end
        valid_o = (ones == 4'd1);
    end

endmodule

// File: rtl/keypad_encoder_nivel2.sv
// Debounces the 10-key keypad and hands one BCD digit per press to the timer:
// data settles one cycle before a single-cycle load strobe, no auto-repeat.
module keypad_encoder_nivel2
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [KEYS-1:0]  keypad,
    input  logic             enable,
    output logic [BCD_W-1:0] data,
    output logic             load,
    output logic             busy,
    output logic [2:0]       digit_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0] code_q, code_d;
    logic [BCD_W-1:0] data_q, data_d;
    logic             load_q, load_d;
    logic             busy_q;
    logic [2:0]       digit_cnt_q, digit_cnt_d;

    logic [BCD_W-1:0] key_code;
    logic             key_valid;

    onehot10_to_bcd u_decode (
        .keys_i  (keypad),
        .code_o  (key_code),
        .valid_o (key_valid)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        data_d      = data_q;
        digit_cnt_d = digit_cnt_q;
        load_d      = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (key_valid) begin
                        state_d = DEBOUNCE;
                        code_d  = key_code;
                        cnt_d   = CNT_ONE;
                    end
                end
                DEBOUNCE: begin
                    if (!key_valid) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (key_code != code_q) begin
                        code_d = key_code;
                        cnt_d  = CNT_ONE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = SETUP;
                        data_d  = code_q;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                // load rises on the edge leaving SETUP, so it is high during STROBE
                SETUP: begin
                    state_d = STROBE;
                    load_d  = 1'b1;
                    if (digit_cnt_q != 3'd7) digit_cnt_d = digit_cnt_q + 3'd1;
                end
                STROBE: begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
                RELEASE: begin
                    if (keypad != '0) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            code_q      <= '0;
            data_q      <= '0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            digit_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            data_q      <= data_d;
            load_q      <= load_d;
            busy_q      <= (state_d != IDLE);
            digit_cnt_q <= digit_cnt_d;
        end
    end

    assign data      = data_q;
    assign load      = load_q;
    assign busy      = busy_q;
    assign digit_cnt = digit_cnt_q;

endmodule

// File: tb/tb_keypad_encoder_nivel2.sv
// Randomized scoreboard bench for keypad_encoder_nivel2 against a sample-history
// reference model of the keypad rules.
module tb_keypad_encoder_nivel2;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       clear;
    logic       enable;
    logic [9:0] keypad;
    logic [3:0] data;
    logic       load;
    logic       busy;
    logic [2:0] digit_cnt;

    always #5 clk = ~clk;

    keypad_encoder_nivel2 #(.DEBOUNCE_CYCLES(DEB), .CNT_W(8)) dut (
        .clk       (clk),
        .clear     (clear),
        .keypad    (keypad),
        .enable    (enable),
        .data      (data),
        .load      (load),
        .busy      (busy),
        .digit_cnt (digit_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int at_cyc;
        int digit;
        int count;
    } exp_t;

    exp_t sb[$];

    // mode: 0 looking for a stable key, 1 digit accepted, 2 strobing, 3 awaiting quiet keypad
    int mode      = 0;
    int run_len   = 0;
    int run_key   = 0;
    int quiet_len = 0;
    int m_data    = 0;
    int m_cnt     = 0;

    function automatic int key_of(input logic [9:0] kp);
        int idx = -1;
        int n   = 0;
        for (int i = 0; i < 10; i++)
            if (kp[i]) begin
                idx = i;
                n++;
            end
        return (n == 1) ? idx : -1;
    endfunction

    function automatic logic [9:0] onehot(input int k);
        logic [9:0] v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    initial forever begin
        @(posedge clk or posedge clear);
        if (clear) begin
            mode = 0; run_len = 0; quiet_len = 0; m_data = 0; m_cnt = 0;
            sb.delete();
        end else begin
            int k;
            cyc++;
            k = key_of(keypad);
            if (!enable) begin
                mode = 0;
                run_len = 0;
            end else if (mode == 0) begin
                if (k < 0) run_len = 0;
                else begin
                    if (run_len > 0 && k == run_key) run_len++;
                    else begin
                        run_key = k;
                        run_len = 1;
                    end
                    if (run_len == DEB) begin
                        m_data  = run_key;
                        run_len = 0;
                        mode    = 1;
                    end
                end
            end else if (mode == 1) begin
                m_cnt = (m_cnt < 7) ? m_cnt + 1 : 7;
                sb.push_back('{at_cyc: cyc, digit: m_data, count: m_cnt});
                mode = 2;
            end else if (mode == 2) begin
                mode = 3;
                quiet_len = 0;
            end else begin
                quiet_len = (keypad == '0) ? quiet_len + 1 : 0;
                if (quiet_len == DEB) mode = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial forever begin
        exp_t e;
        @(negedge clk);
        check("data", data, m_data);
        check("digit_cnt", digit_cnt, m_cnt);
        check("busy", busy, !(mode == 0 && run_len == 0));
        if (load) begin
            if (sb.size() == 0) check("spurious_load", load, 1'b0);
            else begin
                e = sb.pop_front();
                check("load_cycle", cyc, e.at_cyc);
                check("load_data", data, e.digit);
                check("load_cnt", digit_cnt, e.count);
            end
        end else if (sb.size() > 0 && sb[0].at_cyc <= cyc) begin
            e = sb.pop_front();
            check("load_missing", load, 1'b1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic en, input logic [9:0] kp, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            enable = en;
            keypad = kp;
        end
    endtask

    task automatic press(input int k, input int hold, input int gap);
        drive(1'b1, onehot(k), hold);
        drive(1'b1, '0, gap);
    endtask

    initial begin
        bit got;
        clear  = 1'b1;
        enable = 1'b0;
        keypad = '0;
        #2;
        check("rst_data", data, 0);
        check("rst_load", load, 0);
        check("rst_busy", busy, 0);
        check("rst_digit_cnt", digit_cnt, 0);
        @(negedge clk);
        clear = 1'b0;

        // single press held long, then key sequence 2,1,7,9
        press(2, 8, 6);
        press(2, 6, 6); press(1, 6, 6); press(7, 6, 6); press(9, 6, 6);

        // bouncing key 5 then stable
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, onehot(5), 1);
            drive(1'b1, '0, 1);
        end
        press(5, 8, 6);

        // two keys at once: never encoded
        drive(1'b1, 10'b0000100001, 10);
        drive(1'b1, '0, 4);

        // enable dropped mid-debounce, then re-raised with key held
        drive(1'b1, onehot(3), 2);
        drive(1'b0, onehot(3), 1);
        drive(1'b1, onehot(3), 8);
        drive(1'b1, '0, 6);

        // clear during STROBE, then saturate digit_cnt
        drive(1'b1, onehot(4), 1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            got = load;
        end
        check("strobe_seen", load, 1'b1);
        clear = 1'b1;
        #1;
        check("clr_load", load, 0);
        check("clr_data", data, 0);
        check("clr_digit_cnt", digit_cnt, 0);
        check("clr_busy", busy, 0);
        @(negedge clk);
        clear  = 1'b0;
        keypad = '0;
        for (int i = 0; i < 8; i++) press(i, 6, 6);

        // randomized episodes
        for (int ep = 0; ep < 400; ep++) begin
            int r  = $urandom_range(0, 9);
            int k  = $urandom_range(0, 9);
            int k2 = (k + $urandom_range(1, 9)) % 10;
            if (r < 5) press(k, $urandom_range(1, 9), $urandom_range(0, 6));
            else if (r == 5) begin
                for (int b = 0; b < $urandom_range(2, 6); b++) begin
                    drive(1'b1, onehot(k), 1);
                    drive(1'b1, '0, 1);
                end
            end else if (r == 6) drive(1'b1, onehot(k) | onehot(k2), $urandom_range(1, 6));
            else if (r == 7) drive(1'($urandom_range(0, 1)), onehot(k), $urandom_range(1, 6));
            else if (r == 8) drive(1'b1, 10'($urandom), $urandom_range(1, 3));
            else begin
                drive(1'b1, onehot(k), 2);
                drive(1'b1, onehot(k2), 5);
            end
        end

        drive(1'b1, '0, 10);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
